// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO on the write side feeding a baud-timed serialiser.
// Define PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600,
    parameter int FIFO_AW  = 3
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               Wr_En_Sig,
    input  logic [7:0]         Wr_Data,
    output logic               Full_Sig,
    output logic               Empty_Sig,
    output logic [FIFO_AW:0]   Level,
    output logic               Ovf_Sig,
    output logic               Busy_Sig,
    output logic               Tx_Done_Sig,
    output logic               Tx_Pin_Out
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int DEPTH    = 2 ** FIFO_AW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);

`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr;
    logic [FIFO_AW:0]   rd_ptr;
    logic [FIFO_AW:0]   wr_ptr_nxt;
    logic [FIFO_AW:0]   rd_ptr_nxt;
    logic [7:0]         head_byte;
    logic               push;
    logic               pop;
    logic               baud_last;
    logic [CNT_W-1:0]   baud_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;
`ifdef PARITY_EN
    logic               parity_bit;
`endif

    // A full FIFO always rejects the write, even when a pop frees a slot that cycle.
    assign push       = Wr_En_Sig && !Full_Sig;
    assign baud_last  = (baud_cnt == CNT_LAST);
    assign pop        = !Empty_Sig && ((state == IDLE) || ((state == STOP) && baud_last));
    assign head_byte  = mem[rd_ptr[FIFO_AW-1:0]];
    assign wr_ptr_nxt = wr_ptr + {{FIFO_AW{1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr + {{FIFO_AW{1'b0}}, pop};
    assign Busy_Sig   = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= Wr_Data;
        end
    end

    // Status flags are computed from the next pointer values so they settle one cycle after the event.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            Full_Sig  <= 1'b0;
            Empty_Sig <= 1'b1;
            Level     <= '0;
            Ovf_Sig   <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            Full_Sig  <= (wr_ptr_nxt[FIFO_AW] != rd_ptr_nxt[FIFO_AW]) &&
                         (wr_ptr_nxt[FIFO_AW-1:0] == rd_ptr_nxt[FIFO_AW-1:0]);
            Empty_Sig <= (wr_ptr_nxt == rd_ptr_nxt);
            Level     <= wr_ptr_nxt - rd_ptr_nxt;
            Ovf_Sig   <= Wr_En_Sig && Full_Sig;
        end
    end

    // The line bit is registered one step ahead so each state's level appears with the state itself.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            Tx_Pin_Out  <= 1'b1;
            Tx_Done_Sig <= 1'b0;
`ifdef PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            Tx_Done_Sig <= (state == STOP) && (baud_cnt == CNT_PRE);
            case (state)
                IDLE: begin
                    baud_cnt   <= '0;
                    Tx_Pin_Out <= 1'b1;
                    if (pop) begin
                        shift      <= head_byte;
`ifdef PARITY_EN
                        parity_bit <= ^head_byte;
`endif
                        state      <= START;
                        Tx_Pin_Out <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        state      <= DATA;
                        Tx_Pin_Out <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef PARITY_EN
                            state      <= PARITY;
                            Tx_Pin_Out <= parity_bit;
`else
                            state      <= STOP;
                            Tx_Pin_Out <= 1'b1;
`endif
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            Tx_Pin_Out <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    if (baud_last) begin
                        baud_cnt   <= '0;
                        state      <= STOP;
                        Tx_Pin_Out <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift      <= head_byte;
`ifdef PARITY_EN
                            parity_bit <= ^head_byte;
`endif
                            state      <= START;
                            Tx_Pin_Out <= 1'b0;
                        end else begin
                            state      <= IDLE;
                            Tx_Pin_Out <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    baud_cnt   <= '0;
                    Tx_Pin_Out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at BAUD_DIV=10; inputs driven and outputs sampled on the falling edge.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int FIFO_AW  = 3;
    localparam int BIT_CLKS = 10;
`ifdef PARITY_EN
    localparam int FR = 11 * BIT_CLKS;
`else
    localparam int FR = 10 * BIT_CLKS;
`endif

    logic             CLK;
    logic             RST_n;
    logic             Wr_En_Sig;
    logic [7:0]       Wr_Data;
    logic             Full_Sig;
    logic             Empty_Sig;
    logic [FIFO_AW:0] Level;
    logic             Ovf_Sig;
    logic             Busy_Sig;
    logic             Tx_Done_Sig;
    logic             Tx_Pin_Out;

    int pass_count  = 0;
    int check_count = 0;

    uart_tx_fifo #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD),
        .FIFO_AW(FIFO_AW)
    ) dut (
        .CLK(CLK),
        .RST_n(RST_n),
        .Wr_En_Sig(Wr_En_Sig),
        .Wr_Data(Wr_Data),
        .Full_Sig(Full_Sig),
        .Empty_Sig(Empty_Sig),
        .Level(Level),
        .Ovf_Sig(Ovf_Sig),
        .Busy_Sig(Busy_Sig),
        .Tx_Done_Sig(Tx_Done_Sig),
        .Tx_Pin_Out(Tx_Pin_Out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected line level at a given clock offset within a frame of byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int off);
        int slot;
        slot = off / BIT_CLKS;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
`ifdef PARITY_EN
        if (slot == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST_n     = 1'b0;
        Wr_En_Sig = 1'b0;
        Wr_Data   = 8'h00;
        repeat (3) tick();
        check_count++; if (Tx_Pin_Out !== 1'b1) $display("[TB] FAIL reset_tx got %b want 1", Tx_Pin_Out); else pass_count++;
        check_count++; if (Empty_Sig !== 1'b1) $display("[TB] FAIL reset_empty got %b want 1", Empty_Sig); else pass_count++;
        check_count++; if (Full_Sig !== 1'b0) $display("[TB] FAIL reset_full got %b want 0", Full_Sig); else pass_count++;
        check_count++; if (Level !== 4'd0) $display("[TB] FAIL reset_level got %0d want 0", Level); else pass_count++;
        check_count++; if (Busy_Sig !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", Busy_Sig); else pass_count++;
        check_count++; if (Ovf_Sig !== 1'b0) $display("[TB] FAIL reset_ovf got %b want 0", Ovf_Sig); else pass_count++;
        check_count++; if (Tx_Done_Sig !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", Tx_Done_Sig); else pass_count++;
        RST_n = 1'b1;
        repeat (2) tick();
        check_count++; if ({Busy_Sig, Tx_Pin_Out} !== 2'b01) $display("[TB] FAIL post_reset_idle got %b want 01", {Busy_Sig, Tx_Pin_Out}); else pass_count++;
    endtask

    task automatic test_single();
        logic e;
        tick(); Wr_En_Sig = 1'b1; Wr_Data = 8'h55;
        tick(); Wr_En_Sig = 1'b0;
        check_count++; if (Empty_Sig !== 1'b0) $display("[TB] FAIL single_empty got %b want 0", Empty_Sig); else pass_count++;
        check_count++; if (Level !== 4'd1) $display("[TB] FAIL single_level got %0d want 1", Level); else pass_count++;
        check_count++; if (Tx_Pin_Out !== 1'b1) $display("[TB] FAIL single_latency_tx got %b want 1", Tx_Pin_Out); else pass_count++;
        for (int j = 0; j < FR; j++) begin
            tick();
            e = frame_bit(8'h55, j);
            check_count++; if (Tx_Pin_Out !== e) $display("[TB] FAIL single_line@%0d got %b want %b", j, Tx_Pin_Out, e); else pass_count++;
            check_count++; if (Tx_Done_Sig !== (j == FR - 1)) $display("[TB] FAIL single_done@%0d got %b want %b", j, Tx_Done_Sig, (j == FR - 1)); else pass_count++;
            if (j == 0) begin
                check_count++; if (Busy_Sig !== 1'b1) $display("[TB] FAIL single_busy got %b want 1", Busy_Sig); else pass_count++;
            end
        end
        tick();
        check_count++; if (Busy_Sig !== 1'b0) $display("[TB] FAIL single_busy_fall got %b want 0", Busy_Sig); else pass_count++;
        check_count++; if (Tx_Done_Sig !== 1'b0) $display("[TB] FAIL single_done_fall got %b want 0", Tx_Done_Sig); else pass_count++;
        check_count++; if (Tx_Pin_Out !== 1'b1) $display("[TB] FAIL single_idle_tx got %b want 1", Tx_Pin_Out); else pass_count++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic       e;
        tick(); Wr_En_Sig = 1'b1; Wr_Data = 8'hA3;
        tick(); Wr_Data = 8'h0F;
        for (int j = 0; j < 2 * FR; j++) begin
            tick();
            if (j == 0) Wr_En_Sig = 1'b0;
            b = (j < FR) ? 8'hA3 : 8'h0F;
            e = frame_bit(b, j % FR);
            check_count++; if (Tx_Pin_Out !== e) $display("[TB] FAIL b2b_line@%0d got %b want %b", j, Tx_Pin_Out, e); else pass_count++;
            check_count++; if (Tx_Done_Sig !== ((j % FR) == FR - 1)) $display("[TB] FAIL b2b_done@%0d got %b want %b", j, Tx_Done_Sig, ((j % FR) == FR - 1)); else pass_count++;
        end
        tick();
        check_count++; if ({Busy_Sig, Tx_Pin_Out, Empty_Sig} !== 3'b011) $display("[TB] FAIL b2b_idle got %b want 011", {Busy_Sig, Tx_Pin_Out, Empty_Sig}); else pass_count++;
    endtask

    task automatic test_overflow();
        logic e;
        tick(); Wr_En_Sig = 1'b1; Wr_Data = 8'hC5;
        tick(); Wr_En_Sig = 1'b0;
        tick(); Wr_En_Sig = 1'b1; Wr_Data = 8'h01;
        for (int i = 2; i <= 9; i++) begin
            tick(); Wr_Data = 8'(i);
            if (i == 8) begin
                check_count++; if (Level !== 4'd7) $display("[TB] FAIL ovf_level7 got %0d want 7", Level); else pass_count++;
            end
        end
        check_count++; if (Full_Sig !== 1'b1) $display("[TB] FAIL ovf_full got %b want 1", Full_Sig); else pass_count++;
        check_count++; if (Level !== 4'd8) $display("[TB] FAIL ovf_level8 got %0d want 8", Level); else pass_count++;
        check_count++; if (Ovf_Sig !== 1'b0) $display("[TB] FAIL ovf_early got %b want 0", Ovf_Sig); else pass_count++;
        tick(); Wr_En_Sig = 1'b0;
        check_count++; if (Ovf_Sig !== 1'b1) $display("[TB] FAIL ovf_pulse got %b want 1", Ovf_Sig); else pass_count++;
        check_count++; if (Level !== 4'd8) $display("[TB] FAIL ovf_level_hold got %0d want 8", Level); else pass_count++;
        tick();
        check_count++; if (Ovf_Sig !== 1'b0) $display("[TB] FAIL ovf_pulse_end got %b want 0", Ovf_Sig); else pass_count++;
        repeat (FR - 11) tick();
        for (int j = 0; j < 8 * FR; j++) begin
            tick();
            e = frame_bit(8'(j / FR + 1), j % FR);
            check_count++; if (Tx_Pin_Out !== e) $display("[TB] FAIL ovf_line@%0d got %b want %b", j, Tx_Pin_Out, e); else pass_count++;
        end
        tick();
        check_count++; if ({Busy_Sig, Tx_Pin_Out, Empty_Sig} !== 3'b011) $display("[TB] FAIL ovf_no_ninth got %b want 011", {Busy_Sig, Tx_Pin_Out, Empty_Sig}); else pass_count++;
        check_count++; if (Level !== 4'd0) $display("[TB] FAIL ovf_drained got %0d want 0", Level); else pass_count++;
    endtask

    task automatic test_push_pop();
        logic [7:0] order [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
        logic       e;
        tick(); Wr_En_Sig = 1'b1; Wr_Data = 8'h11;
        tick(); Wr_Data = 8'h22;
        tick(); Wr_Data = 8'h33;
        tick(); Wr_Data = 8'h44;
        tick(); Wr_En_Sig = 1'b0;
        repeat (FR - 3) tick();
        check_count++; if (Level !== 4'd3) $display("[TB] FAIL pp_level_before got %0d want 3", Level); else pass_count++;
        check_count++; if (Tx_Done_Sig !== 1'b1) $display("[TB] FAIL pp_done got %b want 1", Tx_Done_Sig); else pass_count++;
        Wr_En_Sig = 1'b1; Wr_Data = 8'h66;
        tick(); Wr_En_Sig = 1'b0;
        check_count++; if (Level !== 4'd3) $display("[TB] FAIL pp_level_after got %0d want 3", Level); else pass_count++;
        for (int j = 0; j < 4 * FR; j++) begin
            e = frame_bit(order[j / FR], j % FR);
            check_count++; if (Tx_Pin_Out !== e) $display("[TB] FAIL pp_line@%0d got %b want %b", j, Tx_Pin_Out, e); else pass_count++;
            tick();
        end
        check_count++; if ({Busy_Sig, Empty_Sig} !== 2'b01) $display("[TB] FAIL pp_idle got %b want 01", {Busy_Sig, Empty_Sig}); else pass_count++;
    endtask

    task automatic test_reset_mid();
        logic e;
        tick(); Wr_En_Sig = 1'b1; Wr_Data = 8'hFF;
        tick(); Wr_Data = 8'h12;
        tick(); Wr_Data = 8'h34;
        tick(); Wr_En_Sig = 1'b0;
        repeat (54) tick();
        check_count++; if ({Busy_Sig, Tx_Pin_Out} !== 2'b11) $display("[TB] FAIL mid_pre got %b want 11", {Busy_Sig, Tx_Pin_Out}); else pass_count++;
        check_count++; if (Level !== 4'd2) $display("[TB] FAIL mid_level_pre got %0d want 2", Level); else pass_count++;
        RST_n = 1'b0;
        #1;
        check_count++; if (Tx_Pin_Out !== 1'b1) $display("[TB] FAIL mid_tx got %b want 1", Tx_Pin_Out); else pass_count++;
        check_count++; if (Empty_Sig !== 1'b1) $display("[TB] FAIL mid_empty got %b want 1", Empty_Sig); else pass_count++;
        check_count++; if (Level !== 4'd0) $display("[TB] FAIL mid_level got %0d want 0", Level); else pass_count++;
        check_count++; if (Busy_Sig !== 1'b0) $display("[TB] FAIL mid_busy got %b want 0", Busy_Sig); else pass_count++;
        tick(); RST_n = 1'b1;
        for (int j = 0; j < 150; j++) begin
            tick();
            check_count++; if ({Busy_Sig, Tx_Pin_Out} !== 2'b01) $display("[TB] FAIL mid_quiet@%0d got %b want 01", j, {Busy_Sig, Tx_Pin_Out}); else pass_count++;
        end
        tick(); Wr_En_Sig = 1'b1; Wr_Data = 8'h5A;
        tick(); Wr_En_Sig = 1'b0;
        for (int j = 0; j < FR; j++) begin
            tick();
            e = frame_bit(8'h5A, j);
            check_count++; if (Tx_Pin_Out !== e) $display("[TB] FAIL mid_new_line@%0d got %b want %b", j, Tx_Pin_Out, e); else pass_count++;
        end
        tick();
        check_count++; if (Busy_Sig !== 1'b0) $display("[TB] FAIL mid_new_idle got %b want 0", Busy_Sig); else pass_count++;
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        logic [7:0] b;
        logic       e;
        tick(); Wr_En_Sig = 1'b1; Wr_Data = 8'h07;
        tick(); Wr_Data = 8'h03;
        for (int j = 0; j < 2 * FR; j++) begin
            tick();
            if (j == 0) Wr_En_Sig = 1'b0;
            b = (j < FR) ? 8'h07 : 8'h03;
            e = frame_bit(b, j % FR);
            check_count++; if (Tx_Pin_Out !== e) $display("[TB] FAIL par_line@%0d got %b want %b", j, Tx_Pin_Out, e); else pass_count++;
            check_count++; if (Tx_Done_Sig !== ((j % FR) == FR - 1)) $display("[TB] FAIL par_done@%0d got %b want %b", j, Tx_Done_Sig, ((j % FR) == FR - 1)); else pass_count++;
            if (j == 95) begin
                check_count++; if (Tx_Pin_Out !== 1'b1) $display("[TB] FAIL par_bit_07 got %b want 1", Tx_Pin_Out); else pass_count++;
            end
            if (j == FR + 95) begin
                check_count++; if (Tx_Pin_Out !== 1'b0) $display("[TB] FAIL par_bit_03 got %b want 0", Tx_Pin_Out); else pass_count++;
            end
        end
        tick();
        check_count++; if (Busy_Sig !== 1'b0) $display("[TB] FAIL par_idle got %b want 0", Busy_Sig); else pass_count++;
    endtask
`endif

    initial begin
        $display("[TB] uart_tx_fifo bench start, frame length %0d clocks", FR);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_pop();
        test_reset_mid();
`ifdef PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter, 8N1 (8 data bits, no parity, 1 stop bit), LSB first, with an internal baud counter and a byte FIFO on the write side. It is the host-to-line counterpart of the receive/loopback path: logic upstream pushes bytes at clock rate, and the block serialises them back-to-back onto the line. Sits between control logic and the top-level tx pin.

Parameters:
CLK_FREQ, 50000000, input clock frequency in Hz
BAUD, 9600, line rate in bit/s; bit period BAUD_DIV = CLK_FREQ/BAUD clocks (integer division, truncated)
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW (8 entries)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST_n  input  1  asynchronous active-low reset
Wr_En_Sig  input  1  write strobe; one byte accepted per cycle when not full
Wr_Data  input  8  byte to transmit
Full_Sig  output  1  FIFO holds 2**FIFO_AW bytes
Empty_Sig  output  1  FIFO holds 0 bytes
Level  output  FIFO_AW+1  current FIFO occupancy
Ovf_Sig  output  1  one-cycle pulse: write dropped because FIFO was full
Busy_Sig  output  1  high while a frame is on the line (any state except IDLE)
Tx_Done_Sig  output  1  one-cycle pulse on the last clock of each stop bit
Tx_Pin_Out  output  1  serial line, idle high

Behaviour:
- Reset (async, RST_n low): Tx_Pin_Out=1, Full_Sig=0, Empty_Sig=1, Level=0, Ovf_Sig=0, Busy_Sig=0, Tx_Done_Sig=0; FIFO pointers, baud counter and bit index cleared; FSM=IDLE. Reset during a frame aborts it; the line goes high immediately, and any buffered bytes are lost.
- FIFO: pointers are FIFO_AW+1 bits; full/empty are derived from pointer MSB compare. Status outputs are registered and valid the cycle after the event.
- Write: when Wr_En_Sig=1 and Full_Sig=0, Wr_Data is stored. When Wr_En_Sig=1 and Full_Sig=1, the byte is dropped and Ovf_Sig pulses the next cycle. This holds even if a pop occurs in the same cycle (full-write is always rejected).
- Simultaneous accepted write and pop: Level is unchanged; the written byte is queued behind the remaining entries.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: line high. If Empty_Sig=0, pop the head byte into the shift register, clear the baud counter, go to START.
  - START: line 0 for BAUD_DIV clocks, then go to DATA with bit index 0.
  - DATA: line = shift[0] for BAUD_DIV clocks per bit, shifting right after each bit. After bit index 7, go to STOP.
  - STOP: line 1 for BAUD_DIV clocks. On the last clock, pulse Tx_Done_Sig. If Empty_Sig=0 in that cycle, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Frame length is exactly 10*BAUD_DIV clocks. Back-to-back frames have zero extra idle clocks.
- Latency: with the block idle and the FIFO empty, a write in cycle N gives Empty_Sig=0 at N+1, pop at N+1, and the start bit on Tx_Pin_Out from N+2.
- Baud counter: counts 0..BAUD_DIV-1; the bit boundary is at BAUD_DIV-1. BAUD_DIV must be at least 2.
- Tx_Pin_Out is driven from a register (glitch-free).

Optional Feature:
PARITY_EN: when defined, an even-parity bit (XOR of the 8 data bits) is sent in a PARITY state between DATA and STOP, for BAUD_DIV clocks. Frame length becomes 11*BAUD_DIV and latency is unchanged. When not defined, there is no PARITY state and the frame is 8N1 as above.

Test Plan:
- Bench setting for all scenarios: CLK_FREQ=1000000, BAUD=100000, so BAUD_DIV=10.
- Reset and single byte: hold RST_n low, then write 0x55 once -> Tx_Pin_Out=1 at reset; start bit low from N+2 for 10 clocks; data bits 1,0,1,0,1,0,1,0 at 10 clocks each; stop high; Tx_Done_Sig pulses once at N+101; Busy_Sig falls the next cycle.
- Back-to-back: write 0xA3, 0x0F in consecutive cycles -> two frames, 200 clocks total, no high gap between the first stop bit and the second start bit; two Tx_Done_Sig pulses 100 clocks apart.
- Full/overflow: while the first frame is in flight, write 9 bytes (0x01..0x09) on consecutive cycles -> Full_Sig=1 with Level=8, Ovf_Sig pulses once for 0x09; bytes 0x01..0x08 appear on the line in order, and 0x09 is never sent.
- Simultaneous push/pop: write in the exact cycle the FSM pops with Level=3 -> Level stays 3 and order is preserved.
- Reset mid-frame: assert RST_n low during DATA bit 4 of 0xFF with 2 bytes queued -> Tx_Pin_Out=1 immediately, Empty_Sig=1, Level=0; after release, no frame is sent until a new write.
- PARITY_EN build: send 0x07 -> parity bit 1, frame 110 clocks; send 0x03 -> parity bit 0.
